// File: rtl/dbus_dmem_resp_pkg.sv
// Shared types for the data-bus memory responder: FSM states and the
// request/response bundles exchanged between the LSU and the data memory.
package dbus_dmem_resp_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } type_dmem_resp_states_e;

    typedef struct packed {
        logic        req;
        logic        w_en;
        logic [31:0] addr;
        logic [31:0] w_data;
        logic [3:0]  sel_byte;
    } type_lsu2dbus_s;

    typedef struct packed {
        logic        ack;
        logic [31:0] r_data;
        logic        err;
    } type_dbus2lsu_s;

    // Width of the wait-state counter (WAIT_CYCLES ranges 0..15).
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dbus_dmem_resp_sram.sv
// Single-port byte-writable synchronous RAM (DEPTH x 32) with
// read-before-write behaviour: a write cycle returns the old word.
module dmem_sram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   w_data,
    output logic [31:0]   r_data
);

    logic [31:0] mem [DEPTH];

    // Byte-lane writes; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][i*8 +: 8] <= w_data[i*8 +: 8];
                end
            end
        end
    end

    // Read register samples the word before any same-edge write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= 32'd0;
        end else if (en) begin
            r_data <= mem[addr];
        end
    end

endmodule

// File: rtl/dbus_dmem_resp.sv
// Data-bus responder (memory end): accepts one LSU load/store at a time,
// inserts WAIT_CYCLES wait states and answers with a one-cycle ack.
// Optional macro DMEM_ADDR_CHK_EN flags out-of-range addresses with err_o
// and blocks their write; without it addresses alias into the array.
module dbus_dmem_resp
    import dbus_dmem_resp_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        w_en_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] w_data_i,
    input  logic [3:0]  sel_byte_i,
    output logic        ack_o,
    output logic [31:0] r_data_o,
    output logic        err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_CNT_INIT =
        (WAIT_CYCLES == 0) ? '0 : WAIT_CNT_W'(WAIT_CYCLES - 1);

    type_dmem_resp_states_e state, state_next;
    logic [WAIT_CNT_W-1:0]  wait_cnt, wait_cnt_next;

    type_lsu2dbus_s req_in;
    type_lsu2dbus_s req_q;
    type_lsu2dbus_s req_cur;
    type_dbus2lsu_s resp;

    logic          fire;
    logic [31:0]   offset;
    logic [AW-1:0] index;
    logic          addr_bad;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [31:0]   mem_rdata;
    logic          ack_q;
    logic          err_q;
    logic          zero_rdata;
    logic          unused_bits;

    assign req_in = '{req: req_i, w_en: w_en_i, addr: addr_i,
                      w_data: w_data_i, sel_byte: sel_byte_i};

    // With zero wait states the access happens on the accepting edge, so
    // the live inputs are used while idle and the latched copy otherwise.
    assign req_cur = (state == DMEM_IDLE) ? req_in : req_q;

    assign offset = req_cur.addr - BASE_ADDR;
    assign index  = offset[AW+1:2];

`ifdef DMEM_ADDR_CHK_EN
    assign addr_bad    = (offset >> (AW + 2)) != 32'd0;
    assign unused_bits = ^{offset[1:0], req_cur.req};
`else
    assign addr_bad    = 1'b0;
    assign unused_bits = ^{offset[1:0], offset[31:AW+2], req_cur.req};
`endif

    // Next-state and wait-counter logic for the IDLE/WAIT/RESP sequence.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            DMEM_IDLE: begin
                if (req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = DMEM_RESP;
                    end else begin
                        wait_cnt_next = WAIT_CNT_INIT;
                        state_next    = DMEM_WAIT;
                    end
                end
            end
            DMEM_WAIT: begin
                if (wait_cnt == '0) begin
                    state_next = DMEM_RESP;
                end else begin
                    wait_cnt_next = wait_cnt - 1'b1;
                end
            end
            DMEM_RESP: begin
                state_next = DMEM_IDLE;
            end
            default: begin
                state_next = DMEM_IDLE;
            end
        endcase
    end

    // RESP lasts one cycle, so entering it marks the single access edge.
    assign fire = (state_next == DMEM_RESP);

    // A reset coinciding with the access edge must not let the write through.
    assign mem_en = fire & ~rst & ~addr_bad;
    assign mem_we = req_cur.w_en ? req_cur.sel_byte : 4'b0000;

    // State, counter and request latch; reset aborts any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DMEM_IDLE;
            wait_cnt <= '0;
            req_q    <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (state == DMEM_IDLE && req_i) begin
                req_q <= req_in;
            end
        end
    end

    // Registered response flags, produced on the edge entering RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            zero_rdata <= 1'b0;
        end else begin
            ack_q <= fire;
            err_q <= fire & addr_bad;
            if (fire) begin
                zero_rdata <= addr_bad;
            end
        end
    end

    dmem_sram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk    (clk),
        .rst    (rst),
        .en     (mem_en),
        .we     (mem_we),
        .addr   (index),
        .w_data (req_cur.w_data),
        .r_data (mem_rdata)
    );

    assign resp = '{ack: ack_q,
                    r_data: zero_rdata ? 32'd0 : mem_rdata,
                    err: err_q};

    assign ack_o    = resp.ack;
    assign r_data_o = resp.r_data;
    assign err_o    = resp.err;

endmodule

// File: tb/tb_dbus_dmem_resp.sv
// Self-checking bench for dbus_dmem_resp: three instances (WAIT_CYCLES 1, 0
// and 15) share the request fields but each has its own req; a word-level
// memory model predicts every response.
module tb_dbus_dmem_resp;

    localparam int          MAIN_DEPTH  = 1024;
    localparam int          SMALL_DEPTH = 64;
    localparam logic [31:0] SMALL_BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req_v = 3'b000;
    logic        w_en = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] w_data = 32'd0;
    logic [3:0]  sel = 4'd0;

    wire  [2:0]  ack_v;
    wire  [2:0]  err_v;
    wire  [31:0] rd0, rd1, rd2;

    int checks = 0;
    int passed = 0;

    typedef struct {
        bit          check_data;
        logic [31:0] data;
        bit          err;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [int];
    logic        prev_ack = 1'b0;

    always #5 clk = ~clk;

    dbus_dmem_resp #(.DEPTH(MAIN_DEPTH), .WAIT_CYCLES(1), .BASE_ADDR(32'h0)) u_dut (
        .clk(clk), .rst(rst), .req_i(req_v[0]), .w_en_i(w_en), .addr_i(addr),
        .w_data_i(w_data), .sel_byte_i(sel), .ack_o(ack_v[0]), .r_data_o(rd0), .err_o(err_v[0])
    );

    dbus_dmem_resp #(.DEPTH(SMALL_DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(SMALL_BASE)) u_dut_w0 (
        .clk(clk), .rst(rst), .req_i(req_v[1]), .w_en_i(w_en), .addr_i(addr),
        .w_data_i(w_data), .sel_byte_i(sel), .ack_o(ack_v[1]), .r_data_o(rd1), .err_o(err_v[1])
    );

    dbus_dmem_resp #(.DEPTH(SMALL_DEPTH), .WAIT_CYCLES(15), .BASE_ADDR(SMALL_BASE)) u_dut_w15 (
        .clk(clk), .rst(rst), .req_i(req_v[2]), .w_en_i(w_en), .addr_i(addr),
        .w_data_i(w_data), .sel_byte_i(sel), .ack_o(ack_v[2]), .r_data_o(rd2), .err_o(err_v[2])
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic int instDepth(input int which);
        return (which == 0) ? MAIN_DEPTH : SMALL_DEPTH;
    endfunction

    function automatic logic [31:0] instBase(input int which);
        return (which == 0) ? 32'h0 : SMALL_BASE;
    endfunction

    function automatic int expLatency(input int which);
        return (which == 0) ? 2 : (which == 1) ? 1 : 16;
    endfunction

    function automatic bit isBad(input int which, input logic [31:0] a);
        logic [31:0] off;
        off = a - instBase(which);
`ifdef DMEM_ADDR_CHK_EN
        return off >= 32'(instDepth(which) * 4);
`else
        return (off == off) ? 1'b0 : 1'b0;
`endif
    endfunction

    function automatic int modelKey(input int which, input logic [31:0] a);
        logic [31:0] off;
        off = a - instBase(which);
        return which * 65536 + int'((off >> 2) % 32'(instDepth(which)));
    endfunction

    function automatic logic [31:0] byteMerge(input logic [31:0] old, input logic [31:0] nw,
                                              input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = nw[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rdOf(input int which);
        return (which == 0) ? rd0 : (which == 1) ? rd1 : rd2;
    endfunction

    // One full transaction on instance 'which'; the model is updated first.
    task automatic applyStimulus(input int which, input bit we, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s,
                                 input bit has_lit, input logic [31:0] lit);
        exp_t e;
        int   key;
        int   cycles;
        bit   got;
        key   = modelKey(which, a);
        e.err = isBad(which, a);
        if (e.err) begin
            e.check_data = 1'b1;
            e.data       = 32'd0;
        end else begin
            e.check_data = model_mem.exists(key);
            e.data       = e.check_data ? model_mem[key] : 32'd0;
            if (we) begin
                if (s == 4'hF) model_mem[key] = d;
                else if (e.check_data) model_mem[key] = byteMerge(e.data, d, s);
                else if (s != 4'h0) model_mem.delete(key);
            end
        end
        if (which == 0) sb_q.push_back(e);
        w_en = we; addr = a; w_data = d; sel = s;
        req_v[which] = 1'b1;
        cycles = 0;
        got    = 1'b0;
        while (!got && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
            got = ack_v[which];
            if (!got) begin
                w_en = 1'($urandom); addr = $urandom; w_data = $urandom; sel = 4'($urandom);
            end
        end
        req_v[which] = 1'b0;
        checkOutput($sformatf("ack_latency_inst%0d", which), 32'(cycles), 32'(expLatency(which)));
        if (!got && which == 0 && sb_q.size() != 0) void'(sb_q.pop_back());
        if (got && which != 0) begin
            if (e.check_data) checkOutput($sformatf("r_data_inst%0d", which), rdOf(which), e.data);
            checkOutput($sformatf("err_inst%0d", which), {31'd0, err_v[which]}, {31'd0, e.err});
        end
        if (got && has_lit) checkOutput($sformatf("literal_inst%0d", which), rdOf(which), lit);
        @(negedge clk);
        @(negedge clk);
    endtask

    // Scoreboard compare for the main instance on every cycle out of reset.
    always @(negedge clk) begin : cmp
        exp_t e;
        if (rst) begin
            prev_ack = 1'b0;
        end else begin
            if (ack_v[0]) begin
                checkOutput("ack_width", {31'd0, prev_ack}, 32'd0);
                if (sb_q.size() == 0) begin
                    checkOutput("ack_unexpected", {31'd0, ack_v[0]}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    if (e.check_data) checkOutput("sb_r_data", rd0, e.data);
                    checkOutput("sb_err", {31'd0, err_v[0]}, {31'd0, e.err});
                end
            end else begin
                checkOutput("err_outside_ack", {31'd0, err_v[0]}, 32'd0);
            end
            prev_ack = ack_v[0];
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        #1 rst = 1'b1;
        #3;
        checkOutput("reset_ack", {29'd0, ack_v}, 32'd0);
        checkOutput("reset_r_data", rd0, 32'd0);
        checkOutput("reset_err", {29'd0, err_v}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Store then load with one wait state.
        applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF);

        // Byte mask: store returns the pre-write word, load the merged word.
        applyStimulus(0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, 32'h0);
        applyStimulus(0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 1'b1, 32'h1122_3344);
        applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h11BB_33DD);

        // AMO-like load/store pair, then zero-mask store leaves memory alone.
        applyStimulus(0, 1'b1, 32'h40, 32'd5, 4'hF, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'd5);
        applyStimulus(0, 1'b1, 32'h40, 32'd12, 4'hF, 1'b1, 32'd5);
        applyStimulus(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'd12);
        applyStimulus(0, 1'b1, 32'h40, 32'hFFFF_FFFF, 4'h0, 1'b1, 32'd12);
        applyStimulus(0, 1'b0, 32'h43, 32'h0, 4'h0, 1'b1, 32'd12);

        // Zero and fifteen wait states, including the last word of the array.
        applyStimulus(1, 1'b1, 32'h1010, 32'hA5A5_0001, 4'hF, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 32'h1010, 32'h0, 4'h0, 1'b1, 32'hA5A5_0001);
        applyStimulus(1, 1'b1, 32'h10FC, 32'h5A5A_00FC, 4'hF, 1'b0, 32'h0);
        applyStimulus(1, 1'b0, 32'h10FC, 32'h0, 4'h0, 1'b1, 32'h5A5A_00FC);
        applyStimulus(2, 1'b1, 32'h1004, 32'h0F0F_1504, 4'hF, 1'b0, 32'h0);
        applyStimulus(2, 1'b0, 32'h1004, 32'h0, 4'h0, 1'b1, 32'h0F0F_1504);

        // Reset during the wait state of a store aborts it completely.
        applyStimulus(0, 1'b1, 32'h8, 32'h1234_5678, 4'hF, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 32'h1234_5678);
        w_en = 1'b1; addr = 32'h8; w_data = 32'h0000_00FF; sel = 4'hF;
        req_v[0] = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        req_v[0] = 1'b0;
        #1;
        checkOutput("midrst_ack", {31'd0, ack_v[0]}, 32'd0);
        checkOutput("midrst_r_data", rd0, 32'd0);
        checkOutput("midrst_err", {31'd0, err_v[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midrst_no_ack", {31'd0, ack_v[0]}, 32'd0);
        end
        applyStimulus(0, 1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 32'h1234_5678);

        // Out-of-range store: flagged when checking is built in, else aliases.
        applyStimulus(0, 1'b1, 32'h0, 32'h0BAD_C0DE, 4'hF, 1'b0, 32'h0);
`ifdef DMEM_ADDR_CHK_EN
        applyStimulus(0, 1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h0);
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0BAD_C0DE);
`else
        applyStimulus(0, 1'b1, 32'h1000, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h0BAD_C0DE);
        applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D);
`endif

        @(negedge clk);
        @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
